// File: rtl/mmio_timer_pkg.sv
// rtl/mmio_timer_pkg.sv - register map and bit positions shared by the mmio_timer files
//   No ports. Offsets are byte offsets inside the 32-byte register window.
package mmio_timer_pkg;

  localparam logic [4:0] OFF_CTRL   = 5'h00;
  localparam logic [4:0] OFF_LOAD   = 5'h04;
  localparam logic [4:0] OFF_COUNT  = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_PRESC  = 5'h10;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_AUTO      = 1;
  localparam int CTRL_IRQEN     = 2;
  localparam int STATUS_EXPIRED = 0;

endpackage

// File: rtl/mmio_timer_if.sv
// rtl/mmio_timer_if.sv - MEM-stage data bus between the CPU and the timer
//   master (CPU side): drives memwrite, memaddr, memwritedata; sees hit, memreaddata, irq
//   slave (timer):     the opposite directions
interface mmio_timer_if;

  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic        hit;
  logic [31:0] memreaddata;
  logic        irq;

  modport master (
    output memwrite, memaddr, memwritedata,
    input  hit, memreaddata, irq
  );

  modport slave (
    input  memwrite, memaddr, memwritedata,
    output hit, memreaddata, irq
  );

endinterface

// File: rtl/mmio_timer_prescaler.sv
// rtl/mmio_timer_prescaler.sv - tick divider used when MMIO_TIMER_PRESCALE_EN is defined
//   clk, reset : clock, asynchronous active-high reset
//   en         : timer enable; counter holds at 0 while low
//   presc      : tick every presc+1 enabled cycles
//   clr        : zeroes the counter (PRESC register write)
//   tick       : one-cycle tick strobe (combinational)
module mmio_timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clr,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt;

  assign tick = en && (cnt == presc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped down-counting timer with expiry interrupt
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : mmio_timer_if.slave (memwrite/memaddr/memwritedata in; hit/memreaddata/irq out)
//   Optional macro MMIO_TIMER_PRESCALE_EN adds the PRESC register and tick prescaler.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0100,
  parameter int          CNT_W     = 32,
  parameter int          PRESC_W   = 16
) (
  input  logic           clk,
  input  logic           reset,
  mmio_timer_if.slave    bus
);

  logic             hit;
  logic [4:0]       off;
  logic [31:0]      wdata;
  logic             wr;
  logic             wr_ctrl, wr_load, wr_count, wr_status;
  logic             raw_tick, tick, expire;
  logic [31:0]      rdata;

  logic             ctrl_en, ctrl_auto, ctrl_irqen;
  logic [CNT_W-1:0] load, count;
  logic             expired;
  logic             irq;

  logic             en_d, auto_d, irqen_d;
  logic [CNT_W-1:0] load_d, count_d;
  logic             expired_d, irq_d;

  logic             unused_addr_bits;
  assign unused_addr_bits = ^bus.memaddr[1:0];

  assign hit   = (bus.memaddr[31:5] == BASE_ADDR[31:5]);
  assign off   = {bus.memaddr[4:2], 2'b00};
  assign wdata = bus.memwritedata;
  assign wr    = bus.memwrite && hit;

  assign wr_ctrl   = wr && (off == OFF_CTRL);
  assign wr_load   = wr && (off == OFF_LOAD);
  assign wr_count  = wr && (off == OFF_COUNT);
  assign wr_status = wr && (off == OFF_STATUS);

`ifdef MMIO_TIMER_PRESCALE_EN
  logic               wr_presc;
  logic [PRESC_W-1:0] presc;

  assign wr_presc = wr && (off == OFF_PRESC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (wr_presc) begin
      presc <= wdata[PRESC_W-1:0];
    end
  end

  mmio_timer_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_en),
    .presc (presc),
    .clr   (wr_presc),
    .tick  (raw_tick)
  );
`else
  localparam int unused_presc_w = PRESC_W;
  assign raw_tick = ctrl_en;
`endif

  // A CPU write to COUNT/LOAD, or a CTRL write clearing EN, swallows the tick
  // entirely so neither a decrement nor an expiry happens on that edge.
  assign tick   = raw_tick && !wr_load && !wr_count && !(wr_ctrl && !wdata[CTRL_EN]);
  assign expire = tick && (count == '0);

  always_comb begin
    en_d      = ctrl_en;
    auto_d    = ctrl_auto;
    irqen_d   = ctrl_irqen;
    load_d    = load;
    count_d   = count;
    expired_d = expired;

    if (tick) begin
      if (count != '0) begin
        count_d = count - CNT_W'(1);
      end else begin
        expired_d = 1'b1;
        if (ctrl_auto) begin
          count_d = load;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    // CPU writes are applied after the tick so they override it; a CTRL write
    // setting EN beats the one-shot disable.
    if (wr_ctrl) begin
      en_d    = wdata[CTRL_EN];
      auto_d  = wdata[CTRL_AUTO];
      irqen_d = wdata[CTRL_IRQEN];
    end
    if (wr_load) begin
      load_d  = wdata[CNT_W-1:0];
      count_d = wdata[CNT_W-1:0];
    end
    if (wr_count) begin
      count_d = wdata[CNT_W-1:0];
    end
    // Set beats clear when both land on the same edge.
    if (wr_status && wdata[STATUS_EXPIRED] && !expire) begin
      expired_d = 1'b0;
    end

    irq_d = expired_d && irqen_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_en    <= 1'b0;
      ctrl_auto  <= 1'b0;
      ctrl_irqen <= 1'b0;
      load       <= '0;
      count      <= '0;
      expired    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ctrl_en    <= en_d;
      ctrl_auto  <= auto_d;
      ctrl_irqen <= irqen_d;
      load       <= load_d;
      count      <= count_d;
      expired    <= expired_d;
      irq        <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[CTRL_EN]    = ctrl_en;
        rdata[CTRL_AUTO]  = ctrl_auto;
        rdata[CTRL_IRQEN] = ctrl_irqen;
      end
      OFF_LOAD:   rdata = 32'(load);
      OFF_COUNT:  rdata = 32'(count);
      OFF_STATUS: rdata[STATUS_EXPIRED] = expired;
`ifdef MMIO_TIMER_PRESCALE_EN
      OFF_PRESC:  rdata = 32'(presc);
`endif
      default:    rdata = '0;
    endcase
  end

  assign bus.hit         = hit;
  assign bus.memreaddata = hit ? rdata : 32'h0;
  assign bus.irq         = irq;

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - scoreboard bench for mmio_timer (honours MMIO_TIMER_PRESCALE_EN)
module tb_mmio_timer;
  import mmio_timer_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0100;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mmio_timer_if bus ();

  mmio_timer #(.BASE_ADDR(BASE), .CNT_W(32), .PRESC_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop_check(input logic [31:0] got);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      check(tag_q.pop_front(), got, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drives one write cycle: exactly one rising edge passes.
  task automatic wr_abs(input logic [31:0] addr, input logic [31:0] data);
    bus.memwrite     = 1'b1;
    bus.memaddr      = addr;
    bus.memwritedata = data;
    @(negedge clk);
    bus.memwrite     = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] data);
    wr_abs(BASE + 32'(off), data);
  endtask

  task automatic rd_abs(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    bus.memaddr = addr;
    #1;
    sb_pop_check(bus.memreaddata);
  endtask

  task automatic rd(input logic [4:0] off, input logic [31:0] exp, input string tag);
    rd_abs(BASE + 32'(off), exp, tag);
  endtask

  task automatic chk_irq(input logic exp, input string tag);
    sb_push(tag, {31'b0, exp});
    sb_pop_check({31'b0, bus.irq});
  endtask

  task automatic chk_hit(input logic exp, input string tag);
    sb_push(tag, {31'b0, exp});
    sb_pop_check({31'b0, bus.hit});
  endtask

  // Counts edges until STATUS.EXPIRED reads 1, bounded at 20.
  task automatic poll_expired(output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      step();
      cycles++;
      bus.memaddr = BASE + 32'(OFF_STATUS);
      #1;
      if (bus.memreaddata[0]) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    bus.memwrite     = 1'b0;
    bus.memaddr      = BASE;
    bus.memwritedata = 32'h0;
    reset            = 1'b1;
    repeat (2) step();
    reset = 1'b0;

    rd(OFF_CTRL,   32'h0, "rst_ctrl");
    rd(OFF_LOAD,   32'h0, "rst_load");
    rd(OFF_COUNT,  32'h0, "rst_count");
    step();
    rd(OFF_STATUS, 32'h0, "rst_status");
    chk_irq(1'b0, "rst_irq");

    // reset asserted mid-count
    wr(OFF_LOAD, 32'd5);
    wr(OFF_CTRL, 32'd1);
    step();
    step();
    rd(OFF_COUNT, 32'd3, "midcount_before_reset");
    reset = 1'b1;
    rd(OFF_COUNT, 32'h0, "async_rst_count");
    rd(OFF_CTRL,  32'h0, "async_rst_ctrl");
    rd(OFF_LOAD,  32'h0, "async_rst_load");
    chk_irq(1'b0, "async_rst_irq");
    step();
    reset = 1'b0;

    // auto-reload, period LOAD+1
    wr(OFF_LOAD, 32'd3);
    wr(OFF_CTRL, 32'd7);
    rd(OFF_COUNT, 32'd3, "auto_c3");
    step();
    rd(OFF_COUNT, 32'd2, "auto_c2");
    step();
    rd(OFF_COUNT, 32'd1, "auto_c1");
    step();
    rd(OFF_COUNT, 32'd0, "auto_c0");
    rd(OFF_STATUS, 32'd0, "auto_not_yet");
    chk_irq(1'b0, "auto_irq_not_yet");
    step();
    rd(OFF_COUNT, 32'd3, "auto_reload");
    rd(OFF_STATUS, 32'd1, "auto_expired");
    chk_irq(1'b1, "auto_irq");
    repeat (3) step();
    rd(OFF_COUNT, 32'd0, "auto_p2_c0");
    step();
    rd(OFF_COUNT, 32'd3, "auto_p2_reload");
    wr(OFF_CTRL, 32'd0);
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, 32'd0, "auto_clear");
    chk_irq(1'b0, "auto_irq_clear");

    // one-shot
    wr(OFF_LOAD, 32'd2);
    wr(OFF_CTRL, 32'd5);
    step();
    step();
    rd(OFF_STATUS, 32'd0, "oneshot_pre");
    step();
    rd(OFF_CTRL,   32'd4, "oneshot_ctrl");
    rd(OFF_COUNT,  32'd0, "oneshot_count");
    rd(OFF_STATUS, 32'd1, "oneshot_status");
    chk_irq(1'b1, "oneshot_irq");
    step();
    step();
    rd(OFF_COUNT, 32'd0, "oneshot_hold");
    chk_irq(1'b1, "oneshot_irq_hold");

    // STATUS clear vs expiry on the same edge
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, 32'd0, "clr_status");
    chk_irq(1'b0, "clr_irq");
    wr(OFF_LOAD, 32'd1);
    wr(OFF_CTRL, 32'd5);
    step();
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, 32'd1, "set_beats_clear");
    chk_irq(1'b1, "set_beats_clear_irq");
    wr(OFF_STATUS, 32'd0);
    rd(OFF_STATUS, 32'd1, "status_write0_noop");
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, 32'd0, "later_clear");
    chk_irq(1'b0, "later_clear_irq");

    // CPU write to COUNT/LOAD beats a tick
    wr(OFF_LOAD, 32'd9);
    wr(OFF_CTRL, 32'd3);
    step();
    rd(OFF_COUNT, 32'd8, "wr_tick_dec");
    wr(OFF_COUNT, 32'd5);
    rd(OFF_COUNT, 32'd5, "wr_count_wins");
    step();
    rd(OFF_COUNT, 32'd4, "wr_count_then_dec");
    wr(OFF_LOAD, 32'd6);
    rd(OFF_COUNT, 32'd6, "wr_load_wins");
    wr(OFF_CTRL, 32'd0);

    // CTRL write clearing EN when expiry is due
    wr(OFF_LOAD, 32'd0);
    wr(OFF_CTRL, 32'd7);
    wr(OFF_CTRL, 32'd0);
    rd(OFF_STATUS, 32'd0, "ctrl_clr_no_expiry");
    rd(OFF_COUNT,  32'd0, "ctrl_clr_count");
    chk_irq(1'b0, "ctrl_clr_irq");

    // EN with COUNT=0 expires on first tick; CTRL write setting EN beats one-shot disable
    wr(OFF_CTRL, 32'd5);
    wr(OFF_CTRL, 32'd5);
    rd(OFF_STATUS, 32'd1, "zero_first_tick");
    rd(OFF_CTRL,   32'd5, "ctrl_set_en_wins");
    chk_irq(1'b1, "zero_first_tick_irq");
    wr(OFF_CTRL, 32'd0);
    wr(OFF_STATUS, 32'd1);
    rd(OFF_STATUS, 32'd0, "zero_clear");

    // decode: outside window and unmapped offset
    wr(OFF_LOAD, 32'd7);
    rd_abs(BASE + 32'h20, 32'h0, "miss_read");
    chk_hit(1'b0, "miss_hit");
    wr_abs(BASE + 32'h20, 32'hFF);
    wr_abs(BASE + 32'h14, 32'hFF);
    rd_abs(BASE + 32'h14, 32'h0, "unmapped_read");
    chk_hit(1'b1, "unmapped_hit");
    rd(OFF_LOAD, 32'd7, "decode_load_kept");
    step();
    rd(OFF_COUNT, 32'd7, "decode_count_kept");
    rd(OFF_CTRL,  32'd0, "decode_ctrl_kept");
    rd_abs(BASE + 32'h06, 32'd7, "addr_low_bits_ignored");
    step();

`ifdef MMIO_TIMER_PRESCALE_EN
    wr(OFF_PRESC, 32'd2);
    rd(OFF_PRESC, 32'd2, "presc_rw");
    wr(OFF_LOAD, 32'd1);
    wr(OFF_CTRL, 32'd3);
    poll_expired(n);
    check("presc_first_expiry", 32'(n), 32'd6);
    wr(OFF_STATUS, 32'd1);
    poll_expired(n);
    check("presc_period_after_clear", 32'(n), 32'd5);
`else
    wr(OFF_PRESC, 32'd5);
    rd(OFF_PRESC, 32'd0, "presc_absent");
    wr(OFF_LOAD, 32'd1);
    wr(OFF_CTRL, 32'd3);
    poll_expired(n);
    check("noprsc_first_expiry", 32'(n), 32'd2);
    wr(OFF_STATUS, 32'd1);
    poll_expired(n);
    check("noprsc_period_after_clear", 32'(n), 32'd1);
`endif
    wr(OFF_CTRL, 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
